// File: rtl/rv32i_core_top.sv
// rtl/rv32i_core_top.sv - single-cycle RV32I core with private instruction and data memories
// Both memories are word arrays indexed by address bits [AW+1:2], so addresses wrap modulo the memory size.

module rv32i_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] index,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  reg [31:0] mem [0:MEM_WORDS-1];

  assign rdata = mem[index];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

module rv32i_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);
  logic [31:0] regFile [0:31];

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regFile[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regFile[rs2_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regFile[i] <= 32'd0;
    end else if (we && rd_addr != 5'd0) begin
      regFile[rd_addr] <= rd_data;
    end
  end
endmodule

module rv32i_core #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] IF_pc,
  input  logic [31:0] instruction,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_be,
  output logic        data_we,
  input  logic [31:0] data_rdata
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                         OP_IMM = 7'h13, OP_REG = 7'h33;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data, rd_data, next_pc, pc_plus4, alu_b, alu_result;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        rd_we, store_req, taken;

  assign opcode   = instruction[6:0];
  assign f3       = instruction[14:12];
  assign imm_i    = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b    = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u    = {instruction[31:12], 12'd0};
  assign imm_j    = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
  assign pc_plus4 = IF_pc + 32'd4;

  rv32i_regfile register_file (
    .clk(clk), .reset(reset),
    .rs1_addr(instruction[19:15]), .rs2_addr(instruction[24:20]),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .we(rd_we), .rd_addr(instruction[11:7]), .rd_data(rd_data)
  );

  assign alu_b     = (opcode == OP_REG) ? rs2_data : imm_i;
  assign data_addr = rs1_data + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign load_half = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
  // A store that coincides with an asynchronous reset must not reach memory.
  assign data_we   = store_req && reset;

  always_comb begin
    case (data_addr[1:0])
      2'd0:    load_byte = data_rdata[7:0];
      2'd1:    load_byte = data_rdata[15:8];
      2'd2:    load_byte = data_rdata[23:16];
      default: load_byte = data_rdata[31:24];
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (f3)
      3'b000: alu_result = (opcode == OP_REG && instruction[30]) ? rs1_data - alu_b : rs1_data + alu_b;
      3'b001: alu_result = rs1_data << alu_b[4:0];
      3'b010: alu_result = {31'd0, $signed(rs1_data) < $signed(alu_b)};
      3'b011: alu_result = {31'd0, rs1_data < alu_b};
      3'b100: alu_result = rs1_data ^ alu_b;
      3'b101: alu_result = instruction[30] ? $unsigned($signed(rs1_data) >>> alu_b[4:0]) : rs1_data >> alu_b[4:0];
      3'b110: alu_result = rs1_data | alu_b;
      default: alu_result = rs1_data & alu_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = rs1_data == rs2_data;
      3'b001: taken = rs1_data != rs2_data;
      3'b100: taken = $signed(rs1_data) < $signed(rs2_data);
      3'b101: taken = $signed(rs1_data) >= $signed(rs2_data);
      3'b110: taken = rs1_data < rs2_data;
      3'b111: taken = rs1_data >= rs2_data;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc    = pc_plus4;
    rd_we      = 1'b0;
    rd_data    = 32'd0;
    store_req  = 1'b0;
    data_be    = 4'b0000;
    data_wdata = 32'd0;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_data = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_data = IF_pc + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; rd_data = pc_plus4; next_pc = IF_pc + imm_j; end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_data = pc_plus4;
          next_pc = (rs1_data + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: if (taken) next_pc = IF_pc + imm_b;
      OP_LOAD: begin
        rd_we = 1'b1;
        case (f3)
          3'b000:  rd_data = {{24{load_byte[7]}}, load_byte};
          3'b001:  rd_data = {{16{load_half[15]}}, load_half};
          3'b010:  rd_data = data_rdata;
          3'b100:  rd_data = {24'd0, load_byte};
          3'b101:  rd_data = {16'd0, load_half};
          default: rd_we = 1'b0;
        endcase
      end
      OP_STORE: begin
        case (f3)
          3'b000: begin store_req = 1'b1; data_be = 4'b0001 << data_addr[1:0]; data_wdata = {4{rs2_data[7:0]}}; end
          3'b001: begin store_req = 1'b1; data_be = data_addr[1] ? 4'b1100 : 4'b0011; data_wdata = {2{rs2_data[15:0]}}; end
          3'b010: begin store_req = 1'b1; data_be = 4'b1111; data_wdata = rs2_data; end
          default: store_req = 1'b0;
        endcase
      end
      OP_IMM, OP_REG: begin rd_we = 1'b1; rd_data = alu_result; end
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) IF_pc <= RESET_PC;
    else        IF_pc <= next_pc;
  end
endmodule

module rv32i_core_top #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic reset
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] pc, instruction, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
  logic        data_we;
  logic        unused_addr_bits;

  // Instruction memory has no write path in hardware; its contents are preloaded.
  rv32i_mem #(.MEM_WORDS(MEM_WORDS)) insn_memory (
    .clk(clk), .index(pc[AW+1:2]), .we(1'b0), .be(4'b0000), .wdata(32'd0), .rdata(instruction)
  );

  rv32i_mem #(.MEM_WORDS(MEM_WORDS)) data_memory (
    .clk(clk), .index(data_addr[AW+1:2]), .we(data_we), .be(data_be), .wdata(data_wdata), .rdata(data_rdata)
  );

  rv32i_core #(.RESET_PC(RESET_PC)) main_core (
    .clk(clk), .reset(reset), .IF_pc(pc), .instruction(instruction),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_be(data_be),
    .data_we(data_we), .data_rdata(data_rdata)
  );

  assign unused_addr_bits = ^{pc[31:AW+2], pc[1:0], data_addr[31:AW+2], data_addr[1:0]};
endmodule

// File: tb/tb_rv32i_core_top.sv
// tb/tb_rv32i_core_top.sv - scoreboard bench for rv32i_core_top against an instruction-level model
// The model interprets each word from the ISA rules; a monitor compares PC and registers after every edge.

module tb_rv32i_core_top;
  logic clk;
  logic reset;

  rv32i_core_top dut (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0][31:0] regs;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_imem [0:1023];
  logic [31:0] m_dmem [0:1023];
  logic [31:0] m_x    [0:31];
  logic [31:0] m_pc;
  int          checks = 0;
  int          errors = 0;
  bit          running = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] alu(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit branch_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic iss_step();
    logic [31:0] w, a, b, imm_i, imm_s, imm_b, imm_j, ea, word, res, nxt;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          wr;
    int          nbytes, lane0;
    w = m_imem[m_pc[11:2]];
    f3 = w[14:12];
    rd = w[11:7];
    a = m_x[w[19:15]];
    b = m_x[w[24:20]];
    imm_i = 32'($signed(w[31:20]));
    imm_s = 32'($signed({w[31:25], w[11:7]}));
    imm_b = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    imm_j = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    nxt = m_pc + 4;
    wr = 0;
    res = 0;
    case (w[6:0])
      7'h37: begin wr = 1; res = {w[31:12], 12'h0}; end
      7'h17: begin wr = 1; res = m_pc + {w[31:12], 12'h0}; end
      7'h6f: begin wr = 1; res = m_pc + 4; nxt = m_pc + imm_j; end
      7'h67: if (f3 == 0) begin wr = 1; res = m_pc + 4; nxt = (a + imm_i) & ~32'd1; end
      7'h63: if (branch_taken(f3, a, b)) nxt = m_pc + imm_b;
      7'h03: begin
        ea = a + imm_i;
        word = m_dmem[ea[11:2]];
        wr = 1;
        case (f3)
          3'd0: res = 32'($signed(word[8*ea[1:0] +: 8]));
          3'd1: res = 32'($signed(word[16*ea[1] +: 16]));
          3'd2: res = word;
          3'd4: res = 32'(word[8*ea[1:0] +: 8]);
          3'd5: res = 32'(word[16*ea[1] +: 16]);
          default: wr = 0;
        endcase
      end
      7'h23: begin
        ea = a + imm_s;
        nbytes = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
        lane0 = (nbytes == 0) ? 0 : (int'(ea[1:0]) & ~(nbytes - 1));
        for (int k = 0; k < nbytes; k++) m_dmem[ea[11:2]][8*(lane0+k) +: 8] = b[8*k +: 8];
      end
      7'h13: begin wr = 1; res = alu(f3, f3 == 3'd5 && w[30], a, imm_i); end
      7'h33: begin wr = 1; res = alu(f3, w[30], a, b); end
      default: wr = 0;
    endcase
    if (wr && rd != 0) m_x[rd] = res;
    m_pc = nxt;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    int          off;
    logic [31:0] nops [0:4];
    nops = '{32'h0000000f, 32'h00000073, 32'h00100073, 32'h34011073, 32'h0000000b};
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    off = $urandom_range(1, 8) * 4;
    if ($urandom_range(0, 1) == 1) off = -off;
    case ($urandom_range(0, 11))
      0: return {20'($urandom), rd, 7'h37};
      1: return {20'($urandom), rd, 7'h17};
      2, 3: begin
        if (f3 == 3'd1) imm = {7'd0, imm[4:0]};
        if (f3 == 3'd5) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      4, 5: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      6: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
        return enc_i(imm, rs1, f3, rd, 7'h03);
      end
      7: return enc_s(imm, rs2, rs1, 3'($urandom_range(0, 2)));
      8: begin
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd1;
        return enc_b(13'(off), rs2, rs1, f3);
      end
      9: return enc_j(21'(off), rd);
      10: return enc_i(imm, rs1, 3'd0, rd, 7'h67);
      default: return ($urandom_range(0, 5) == 5) ? 32'h0 : nops[$urandom_range(0, 4)];
    endcase
  endfunction

  task automatic check_regs_zero(input string name);
    int bad;
    bad = -1;
    for (int i = 31; i >= 0; i--) if (dut.main_core.register_file.regFile[i] !== 32'd0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: x%0d got %08h expected 00000000", name, bad, dut.main_core.register_file.regFile[bad]);
    end
  endtask

  task automatic check_dmem(input string name);
    int bad;
    bad = -1;
    for (int i = 1023; i >= 0; i--) if (dut.data_memory.mem[i] !== m_dmem[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: word %0d got %08h expected %08h", name, bad, dut.data_memory.mem[bad], m_dmem[bad]);
    end
  endtask

  // Called with reset held low: preload both memories, predict the trace, then release reset.
  task automatic start_prog(input int steps);
    exp_t e;
    for (int i = 0; i < 1024; i++) begin
      dut.insn_memory.mem[i] = m_imem[i];
      dut.data_memory.mem[i] = m_dmem[i];
    end
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    q.delete();
    for (int s = 0; s < steps; s++) begin
      iss_step();
      e.pc = m_pc;
      for (int i = 0; i < 32; i++) e.regs[i] = m_x[i];
      q.push_back(e);
    end
    @(negedge clk);
    reset = 1'b1;
    chk("reset_pc", dut.main_core.IF_pc, 32'd0);
    chk("reset_insn", dut.main_core.instruction, m_imem[0]);
    check_regs_zero("reset_regs");
    running = 1;
  endtask

  task automatic finish_prog(input int steps);
    for (int c = 0; c < steps + 20 && q.size() != 0; c++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending expected 0", q.size());
    end
    running = 0;
  endtask

  initial begin : monitor
    exp_t e;
    int   bad;
    forever begin
      @(posedge clk);
      #1;
      if (running && q.size() != 0) begin
        e = q.pop_front();
        chk("step_pc", dut.main_core.IF_pc, e.pc);
        bad = -1;
        for (int i = 31; i >= 0; i--) if (dut.main_core.register_file.regFile[i] !== e.regs[i]) bad = i;
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL step_regs: x%0d got %08h expected %08h at pc %08h", bad,
                   dut.main_core.register_file.regFile[bad], e.regs[bad], e.pc);
        end
      end
    end
  end

  task automatic load_directed();
    for (int i = 0; i < 1024; i++) begin m_imem[i] = 32'd0; m_dmem[i] = 32'd0; end
    m_imem[0]  = enc_i(12'hfff, 5'd0, 3'd0, 5'd1, 7'h13);
    m_imem[1]  = enc_i(12'd5, 5'd0, 3'd0, 5'd2, 7'h13);
    m_imem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    m_imem[3]  = enc_i(12'd0, 5'd0, 3'd2, 5'd5, 7'h03);
    m_imem[4]  = enc_i(12'd3, 5'd0, 3'd0, 5'd6, 7'h03);
    m_imem[5]  = enc_i(12'd3, 5'd0, 3'd4, 5'd7, 7'h03);
    m_imem[6]  = enc_s(12'd5, 5'd2, 5'd0, 3'd0);
    m_imem[7]  = enc_i(12'd4, 5'd0, 3'd2, 5'd8, 7'h03);
    m_imem[8]  = enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13);
    m_imem[9]  = enc_i(12'd3, 5'd0, 3'd0, 5'd1, 7'h13);
    m_imem[10] = enc_i(12'hfff, 5'd1, 3'd0, 5'd1, 7'h13);
    m_imem[11] = enc_b(13'h1ffc, 5'd0, 5'd1, 3'd1);
    m_imem[12] = enc_j(21'd8, 5'd9);
    m_imem[13] = enc_i(12'd1, 5'd0, 3'd0, 5'd10, 7'h13);
    m_imem[14] = enc_i(12'd2, 5'd0, 3'd0, 5'd11, 7'h13);
    m_dmem[0]  = 32'h997b5853;
    m_dmem[1]  = 32'h00000001;
  endtask

  initial begin : stimulus
    reset = 1'b0;
    #45;

    load_directed();
    start_prog(20);
    finish_prog(20);
    chk("x0", dut.main_core.register_file.regFile[0], 32'd0);
    chk("x1", dut.main_core.register_file.regFile[1], 32'd0);
    chk("x2", dut.main_core.register_file.regFile[2], 32'd5);
    chk("x3", dut.main_core.register_file.regFile[3], 32'd4);
    chk("x5", dut.main_core.register_file.regFile[5], 32'h997b5853);
    chk("x6", dut.main_core.register_file.regFile[6], 32'hffffff99);
    chk("x7", dut.main_core.register_file.regFile[7], 32'h00000099);
    chk("x8", dut.main_core.register_file.regFile[8], 32'h00000501);
    chk("x9", dut.main_core.register_file.regFile[9], 32'd52);
    chk("x10", dut.main_core.register_file.regFile[10], 32'd0);
    chk("x11", dut.main_core.register_file.regFile[11], 32'd2);
    chk("dmem1", dut.data_memory.mem[1], 32'h00000501);
    chk("final_pc", dut.main_core.IF_pc, 32'd68);
    check_dmem("directed_dmem");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    load_directed();
    start_prog(20);
    repeat (13) @(posedge clk);
    #3;
    running = 0;
    q.delete();
    reset = 1'b0;
    #1;
    chk("midrun_pc", dut.main_core.IF_pc, 32'd0);
    check_regs_zero("midrun_regs");
    dut.insn_memory.mem[0] = enc_s(12'd8, 5'd0, 5'd0, 3'd2);
    dut.data_memory.mem[2] = 32'hdeadbeef;
    repeat (3) @(negedge clk);
    chk("reset_no_store", dut.data_memory.mem[2], 32'hdeadbeef);
    chk("reset_hold_pc", dut.main_core.IF_pc, 32'd0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 1024; i++) begin
        m_imem[i] = rand_insn();
        m_dmem[i] = $urandom;
      end
      start_prog(300);
      finish_prog(300);
      check_dmem("random_dmem");
      reset = 1'b0;
      repeat (2) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
